// File: rtl/vision_pkg.sv
// Shared constants and payload types for the vision pipeline stages.
package vision_pkg;

    // BT.601 luma weights, scaled by 2^FRAC_BITS, plus round-half-up constant.
    localparam int unsigned BT601_COEF_R = 77;
    localparam int unsigned BT601_COEF_G = 150;
    localparam int unsigned BT601_COEF_B = 29;
    localparam int unsigned FRAC_BITS    = 8;
    localparam int unsigned ROUND_CONST  = 128;

    // Channel slots inside a packed RGB word (B in the least significant slot).
    localparam int unsigned CH_B   = 0;
    localparam int unsigned CH_G   = 1;
    localparam int unsigned CH_R   = 2;
    localparam int unsigned NUM_CH = 3;

    localparam int unsigned IMG_WIDTH_W       = 16;
    localparam int unsigned DEFAULT_IMG_WIDTH = 1920;

    typedef struct packed {
        logic tuser;
        logic tlast;
    } axis_side_t;

    // Index of the final column of a line; a zero width behaves as one pixel.
    function automatic logic [IMG_WIDTH_W-1:0] last_col(input logic [IMG_WIDTH_W-1:0] width);
        return (width == '0) ? '0 : width - IMG_WIDTH_W'(1);
    endfunction

endpackage

// File: rtl/line_pos_checker.sv
// Tracks the column of accepted beats and raises sticky flags when tlast
// disagrees with the latched line width.
module line_pos_checker
    import vision_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   beat,
    input  logic                   sof,
    input  logic                   eol,
    input  logic [IMG_WIDTH_W-1:0] img_width,
    input  logic                   err_clr,
    output logic                   err_short_line,
    output logic                   err_long_line
);

    logic [IMG_WIDTH_W-1:0] col_q;
    logic [IMG_WIDTH_W-1:0] width_q;
    logic [IMG_WIDTH_W-1:0] cur_col_c;
    logic [IMG_WIDTH_W-1:0] last_col_c;
    logic [IMG_WIDTH_W-1:0] col_d_c;
    logic                   short_ev_c;
    logic                   long_ev_c;

    // A start-of-frame beat is column 0 and is judged against the width it carries.
    always_comb begin
        cur_col_c  = sof ? '0 : col_q;
        last_col_c = last_col(sof ? img_width : width_q);
        short_ev_c = 1'b0;
        long_ev_c  = 1'b0;
        col_d_c    = col_q;
        if (beat) begin
            short_ev_c = eol && (cur_col_c < last_col_c);
            long_ev_c  = !eol && (cur_col_c >= last_col_c);
            col_d_c    = (eol || (cur_col_c >= last_col_c)) ? '0 : cur_col_c + IMG_WIDTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            width_q <= IMG_WIDTH_W'(DEFAULT_IMG_WIDTH);
        end else begin
            col_q <= col_d_c;
            if (beat && sof) begin
                width_q <= img_width;
            end
        end
    end

    // A new error event takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_short_line <= 1'b0;
            err_long_line  <= 1'b0;
        end else begin
            if (short_ev_c) begin
                err_short_line <= 1'b1;
            end else if (err_clr) begin
                err_short_line <= 1'b0;
            end
            if (long_ev_c) begin
                err_long_line <= 1'b1;
            end else if (err_clr) begin
                err_long_line <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rgb_to_gray.sv
// Three-stage BT.601 RGB-to-luma converter on AXI4-Stream with full
// backpressure and line-length checking on the input side.
module rgb_to_gray
    import vision_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COEF_R     = BT601_COEF_R,
    parameter int unsigned COEF_G     = BT601_COEF_G,
    parameter int unsigned COEF_B     = BT601_COEF_B
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                         s_axis_tlast,
    input  logic                         s_axis_tuser,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    input  logic [IMG_WIDTH_W-1:0]       img_width,
    input  logic                         err_clr,
    output logic                         err_short_line,
    output logic                         err_long_line
);

    localparam int unsigned PW = DATA_WIDTH + 8;
    localparam int unsigned SW = DATA_WIDTH + 10;

    logic                  ce_c;
    logic                  accept_c;
    logic [DATA_WIDTH-1:0] ch_r_c;
    logic [DATA_WIDTH-1:0] ch_g_c;
    logic [DATA_WIDTH-1:0] ch_b_c;

    logic                  v1_q;
    logic [PW-1:0]         p_r_q;
    logic [PW-1:0]         p_g_q;
    logic [PW-1:0]         p_b_q;
    axis_side_t            side1_q;

    logic                  v2_q;
    logic [SW-1:0]         sum2_q;
    axis_side_t            side2_q;

    logic                  v3_q;
    logic [DATA_WIDTH-1:0] data3_q;
    axis_side_t            side3_q;

    // Whole pipeline moves in lockstep; bubbles are squeezed out whenever the output is free.
    assign ce_c          = m_axis_tready || !v3_q;
    assign accept_c      = s_axis_tvalid && ce_c;
    assign s_axis_tready = ce_c;

    assign ch_r_c = s_axis_tdata[CH_R*DATA_WIDTH +: DATA_WIDTH];
    assign ch_g_c = s_axis_tdata[CH_G*DATA_WIDTH +: DATA_WIDTH];
    assign ch_b_c = s_axis_tdata[CH_B*DATA_WIDTH +: DATA_WIDTH];

    // Weights sum to 256, so the rounded, scaled sum always fits DATA_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            p_r_q   <= '0;
            p_g_q   <= '0;
            p_b_q   <= '0;
            side1_q <= '0;
            v2_q    <= 1'b0;
            sum2_q  <= '0;
            side2_q <= '0;
            v3_q    <= 1'b0;
            data3_q <= '0;
            side3_q <= '0;
        end else if (ce_c) begin
            v1_q    <= s_axis_tvalid;
            p_r_q   <= PW'(ch_r_c) * PW'(COEF_R);
            p_g_q   <= PW'(ch_g_c) * PW'(COEF_G);
            p_b_q   <= PW'(ch_b_c) * PW'(COEF_B);
            side1_q <= '{tuser: s_axis_tuser, tlast: s_axis_tlast};

            v2_q    <= v1_q;
            sum2_q  <= SW'(p_r_q) + SW'(p_g_q) + SW'(p_b_q) + SW'(ROUND_CONST);
            side2_q <= side1_q;

            v3_q    <= v2_q;
            data3_q <= DATA_WIDTH'(sum2_q >> FRAC_BITS);
            side3_q <= side2_q;
        end
    end

    assign m_axis_tvalid = v3_q;
    assign m_axis_tdata  = data3_q;
    assign m_axis_tlast  = side3_q.tlast;
    assign m_axis_tuser  = side3_q.tuser;

    line_pos_checker u_line_pos_checker (
        .clk            (clk),
        .rst_n          (rst_n),
        .beat           (accept_c),
        .sof            (s_axis_tuser),
        .eol            (s_axis_tlast),
        .img_width      (img_width),
        .err_clr        (err_clr),
        .err_short_line (err_short_line),
        .err_long_line  (err_long_line)
    );

endmodule

// File: tb/tb_rgb_to_gray.sv
// Directed bench for rgb_to_gray: luma values, latency, stalls, framing and line errors.
module tb_rgb_to_gray;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid;
    logic        s_tready;
    logic [23:0] s_tdata;
    logic        s_tlast;
    logic        s_tuser;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        m_tuser;
    logic [15:0] img_width;
    logic        err_clr;
    logic        err_short;
    logic        err_long;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  outq[$];

    always #5 clk = ~clk;

    rgb_to_gray dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tdata   (s_tdata),
        .s_axis_tlast   (s_tlast),
        .s_axis_tuser   (s_tuser),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tlast   (m_tlast),
        .m_axis_tuser   (m_tuser),
        .img_width      (img_width),
        .err_clr        (err_clr),
        .err_short_line (err_short),
        .err_long_line  (err_long)
    );

    // Record every output beat that will transfer on the coming edge as {tuser, tlast, data}.
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) outq.push_back({m_tuser, m_tlast, m_tdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one beat just after a rising edge; it is accepted on the next edge (ready held high).
    task automatic drive_beat(input logic [23:0] d, input logic u, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic single_beat(input string tag, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b, input logic [7:0] exp);
        drive_beat({r, g, b}, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_early"}, 32'(m_tvalid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(m_tvalid), 32'd1);
        check({tag, "_data"}, 32'(m_tdata), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int         sent;
        logic [9:0] exp_beat;

        rst_n     = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        s_tlast   = 1'b0;
        s_tuser   = 1'b0;
        m_tready  = 1'b1;
        img_width = 16'd4;
        err_clr   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tuser", 32'(m_tuser), 32'd0);
        check("rst_err_short", 32'(err_short), 32'd0);
        check("rst_err_long", 32'(err_long), 32'd0);
        check("rst_tready", 32'(s_tready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Single beats: (256*luma_sum + 128) >> 8
        single_beat("white", 8'd255, 8'd255, 8'd255, 8'd255);
        single_beat("red",   8'd255, 8'd0,   8'd0,   8'd77);
        single_beat("green", 8'd0,   8'd255, 8'd0,   8'd149);
        single_beat("blue",  8'd0,   8'd0,   8'd255, 8'd29);
        single_beat("black", 8'd0,   8'd0,   8'd0,   8'd0);
        single_beat("mix",   8'd128, 8'd64,  8'd32,  8'd80);
        idle(3);

        // 16-beat grey ramp with downstream stalled on cycles 4..8
        outq.delete();
        sent = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            m_tready = !(cyc >= 4 && cyc <= 8);
            s_tvalid = (sent < 16);
            s_tdata  = {sent[7:0], sent[7:0], sent[7:0]};
            @(negedge clk);
            if (cyc >= 2 && cyc <= 10)
                check($sformatf("stall_tready_c%0d", cyc), 32'(s_tready), 32'(!(cyc >= 4 && cyc <= 8)));
            if (s_tvalid && s_tready) sent++;
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        check("stream_count", 32'(outq.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            exp_beat = {2'b00, 8'(i)};
            if (i < outq.size()) check($sformatf("stream_beat%0d", i), 32'(outq[i]), 32'(exp_beat));
        end

        // Well-formed 4-pixel line: sideband aligned with pixels, no errors
        outq.delete();
        img_width = 16'd4;
        for (int i = 0; i < 4; i++) drive_beat({3{8'(i * 10)}}, i == 0, i == 3);
        idle(5);
        check("frame_count", 32'(outq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            exp_beat = {i == 0, i == 3, 8'(i * 10)};
            if (i < outq.size()) check($sformatf("frame_beat%0d", i), 32'(outq[i]), 32'(exp_beat));
        end
        check("frame_err_short", 32'(err_short), 32'd0);
        check("frame_err_long", 32'(err_long), 32'd0);

        // Short line: tlast at column 2 of 4
        drive_beat(24'd0, 1'b1, 1'b0);
        drive_beat(24'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("short_before", 32'(err_short), 32'd0);
        @(posedge clk); #1;
        drive_beat(24'd0, 1'b0, 1'b1);
        @(negedge clk);
        check("short_set", 32'(err_short), 32'd1);
        check("short_no_long", 32'(err_long), 32'd0);
        @(posedge clk); #1;
        pulse_clr();
        @(negedge clk);
        check("short_cleared", 32'(err_short), 32'd0);
        @(posedge clk); #1;

        // Long line: 5 beats, no tlast at column 3
        for (int i = 0; i < 5; i++) begin
            drive_beat(24'd0, 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("long_beat%0d", i), 32'(err_long), 32'(i >= 3));
            @(posedge clk); #1;
        end
        check("long_no_short", 32'(err_short), 32'd0);
        idle(4);
        pulse_clr();
        @(negedge clk);
        check("clr_long", 32'(err_long), 32'd0);
        check("clr_short", 32'(err_short), 32'd0);
        @(posedge clk); #1;

        // Clear coincident with a short-line event: set wins
        drive_beat(24'd0, 1'b1, 1'b0);
        err_clr = 1'b1;
        drive_beat(24'd0, 1'b0, 1'b1);
        err_clr = 1'b0;
        @(negedge clk);
        check("set_beats_clr", 32'(err_short), 32'd1);
        @(posedge clk); #1;
        idle(4);

        // Reset with three beats in flight
        outq.delete();
        drive_beat({3{8'd11}}, 1'b1, 1'b0);
        drive_beat({3{8'd22}}, 1'b0, 1'b0);
        drive_beat({3{8'd33}}, 1'b0, 1'b0);
        check("inflight_valid", 32'(m_tvalid), 32'd1);
        check("inflight_err_short", 32'(err_short), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst_tdata", 32'(m_tdata), 32'd0);
        check("midrst_err_short", 32'(err_short), 32'd0);
        check("midrst_err_long", 32'(err_long), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        outq.delete();
        idle(6);
        check("postrst_no_stale", 32'(outq.size()), 32'd0);
        check("postrst_tvalid", 32'(m_tvalid), 32'd0);

        // Default width 1920 and cleared column: an exact 1920-pixel line is clean
        for (int i = 0; i < 1920; i++) drive_beat({3{8'(i)}}, 1'b0, i == 1919);
        idle(5);
        check("dflt_err_short", 32'(err_short), 32'd0);
        check("dflt_err_long", 32'(err_long), 32'd0);
        check("dflt_count", 32'(outq.size()), 32'd1920);
        if (outq.size() == 1920) begin
            exp_beat = {1'b0, 1'b1, 8'd127};
            check("dflt_last_beat", 32'(outq[1919]), 32'(exp_beat));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
